// File: rtl/dst_reg_scoreboard.sv
// dst_reg_scoreboard
//   Decode-stage hazard controller for the destination-register path.
//   Resolves each issuing instruction's write target (rt / r31 / rd), counts
//   in-flight writes per architectural register and stalls issue while a
//   source operand still has a pending writer.
//
// Configuration macro: SCOREBOARD_FWD_EN
//   defined   : ALU results are forwarded, so only a pending load stalls a
//               reader (load-use); the structural stall is unchanged.
//   undefined : any pending writer stalls a reader.
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   issue_valid                    decode presents an instruction
//   issue_rs/rt/rd [NBITS]         instruction register fields
//   issue_use_rs, issue_use_rt     operand actually read
//   issue_wr                       instruction writes a register
//   issue_sel_reg [2]              00 rt, 01 r31, 10 rd, 11 no write
//   issue_is_load                  instruction is a load
//   wb_valid, wb_reg [NBITS]       write-back retires a write
//   flush                          discard all in-flight tracking
//   stall, issue_ready             combinational issue control
//   busy_vec [NREGS]               registered per-register pending flag
//   err                            sticky overflow/underflow flag
module dst_reg_scoreboard #(
  parameter int NBITS   = 5,
  parameter int NREGS   = 32,
  parameter int CNTBITS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               issue_valid,
  input  logic [NBITS-1:0]   issue_rs,
  input  logic [NBITS-1:0]   issue_rt,
  input  logic [NBITS-1:0]   issue_rd,
  input  logic               issue_use_rs,
  input  logic               issue_use_rt,
  input  logic               issue_wr,
  input  logic [1:0]         issue_sel_reg,
  input  logic               issue_is_load,
  input  logic               wb_valid,
  input  logic [NBITS-1:0]   wb_reg,
  input  logic               flush,
  output logic               stall,
  output logic               issue_ready,
  output logic [NREGS-1:0]   busy_vec,
  output logic               err
);

  logic [CNTBITS-1:0] r_pend [NREGS];
  logic [NREGS-1:0]   r_ld;
  logic [NREGS-1:0]   r_busy;
  logic               r_err;

  logic [NBITS-1:0]   w_dst;
  logic               w_dst_wr;
  logic [CNTBITS-1:0] w_eff_rs;
  logic [CNTBITS-1:0] w_eff_rt;
  logic               w_haz_rs;
  logic               w_haz_rt;
  logic               w_struct;
  logic               w_stall;
  logic               w_ready;
  logic [NREGS-1:0]   w_inc;
  logic [NREGS-1:0]   w_dec;
  logic [CNTBITS-1:0] w_pend_nxt [NREGS];
  logic [NREGS-1:0]   w_ld_nxt;
  logic [NREGS-1:0]   w_busy_nxt;
  logic               w_err_set;

  // Destination decode; register 0 is never tracked.
  always_comb begin
    w_dst = '0;
    unique case (issue_sel_reg)
      2'b00:   w_dst = issue_rt;
      2'b01:   w_dst = '1;
      2'b10:   w_dst = issue_rd;
      default: w_dst = '0;
    endcase
    w_dst_wr = issue_wr && (issue_sel_reg != 2'b11) && (w_dst != '0);
  end

  // Effective count: a same-cycle retire is already visible to decode
  // through the write-through register file.
  always_comb begin
    w_eff_rs = r_pend[issue_rs] - CNTBITS'(wb_valid && (wb_reg == issue_rs) &&
                                           (r_pend[issue_rs] != '0));
    w_eff_rt = r_pend[issue_rt] - CNTBITS'(wb_valid && (wb_reg == issue_rt) &&
                                           (r_pend[issue_rt] != '0));
`ifdef SCOREBOARD_FWD_EN
    w_haz_rs = issue_use_rs && (issue_rs != '0) && (w_eff_rs != '0) && r_ld[issue_rs];
    w_haz_rt = issue_use_rt && (issue_rt != '0) && (w_eff_rt != '0) && r_ld[issue_rt];
`else
    w_haz_rs = issue_use_rs && (issue_rs != '0) && (w_eff_rs != '0);
    w_haz_rt = issue_use_rt && (issue_rt != '0) && (w_eff_rt != '0);
`endif
    w_struct = w_dst_wr && (r_pend[w_dst] == '1);
    w_stall  = rst_n && issue_valid && !flush && (w_haz_rs || w_haz_rt || w_struct);
    w_ready  = rst_n && issue_valid && !flush && !w_stall;
  end

  assign stall       = w_stall;
  assign issue_ready = w_ready;
  assign busy_vec    = r_busy;
  assign err         = r_err;

  // Next-state of the per-register tracking; flush overrides issue/retire.
  always_comb begin
    w_inc      = '0;
    w_dec      = '0;
    w_ld_nxt   = '0;
    w_busy_nxt = '0;
    w_err_set  = 1'b0;
    for (int unsigned r = 0; r < NREGS; r++) w_pend_nxt[r] = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      w_inc[r] = w_ready && w_dst_wr && (w_dst == NBITS'(r));
      w_dec[r] = wb_valid && (wb_reg == NBITS'(r)) && (r_pend[r] != '0);
      w_pend_nxt[r] = r_pend[r] + CNTBITS'(w_inc[r]) - CNTBITS'(w_dec[r]);
      w_ld_nxt[r]   = w_inc[r] ? issue_is_load : r_ld[r];
      if (w_pend_nxt[r] == '0) w_ld_nxt[r] = 1'b0;
      if (w_inc[r] && !w_dec[r] && (r_pend[r] == '1)) w_err_set = 1'b1;
      if (flush) begin
        w_pend_nxt[r] = '0;
        w_ld_nxt[r]   = 1'b0;
      end
      w_busy_nxt[r] = (w_pend_nxt[r] != '0);
    end
    if (!flush && wb_valid && (wb_reg != '0) && (r_pend[wb_reg] == '0))
      w_err_set = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREGS; r++) r_pend[r] <= '0;
      r_ld   <= '0;
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) r_pend[r] <= w_pend_nxt[r];
      r_ld   <= w_ld_nxt;
      r_busy <= w_busy_nxt;
      r_err  <= r_err | w_err_set;
    end
  end

endmodule

// File: tb/tb_dst_reg_scoreboard.sv
module tb_dst_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rs, issue_rt, issue_rd;
  logic        issue_use_rs, issue_use_rt, issue_wr;
  logic [1:0]  issue_sel_reg;
  logic        issue_is_load;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic        flush;
  logic        stall, issue_ready, err;
  logic [31:0] busy_vec;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dst_reg_scoreboard #(.NBITS(5), .NREGS(32), .CNTBITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
    .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rd(issue_rd),
    .issue_use_rs(issue_use_rs), .issue_use_rt(issue_use_rt),
    .issue_wr(issue_wr), .issue_sel_reg(issue_sel_reg),
    .issue_is_load(issue_is_load), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .flush(flush), .stall(stall), .issue_ready(issue_ready),
    .busy_vec(busy_vec), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_rd = 0;
    issue_use_rs = 0; issue_use_rt = 0; issue_wr = 0; issue_sel_reg = 2'b11;
    issue_is_load = 0; wb_valid = 0; wb_reg = 0; flush = 0;
  endtask

  // writer with destination select and field
  task automatic wr_op(input logic [1:0] sel, input logic [4:0] r, input logic ld);
    idle();
    issue_valid = 1; issue_wr = 1; issue_sel_reg = sel; issue_is_load = ld;
    if (sel == 2'b00) issue_rt = r; else issue_rd = r;
  endtask

  task automatic rd_rs(input logic [4:0] r);
    idle();
    issue_valid = 1; issue_use_rs = 1; issue_rs = r;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst_n = 0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_ready", issue_ready, 0);
    chk("rst_busy", busy_vec, 0);
    chk("rst_err", err, 0);
    cyc(); cyc();
    rst_n = 1;

    // rd writer then reader, retire two cycles later
    wr_op(2'b10, 5'd8, 0); #1;
    chk("t1_issue_ready", issue_ready, 1);
    cyc();
    chk("t1_busy8", busy_vec, 32'h0000_0100);
    rd_rs(5'd8); #1;
    chk("t1_stall_a", stall, 1);
    chk("t1_ready_a", issue_ready, 0);
    cyc(); #1;
    chk("t1_stall_b", stall, 1);
    cyc();
    wb_valid = 1; wb_reg = 5'd8; #1;
    chk("t1_stall_ret", stall, 0);
    chk("t1_ready_ret", issue_ready, 1);
    chk("t1_busy_lag", busy_vec, 32'h0000_0100);
    cyc(); idle(); #1;
    chk("t1_busy_drop", busy_vec, 0);

    // three r31 writers fill the counter; fourth is a structural stall
    for (int i = 0; i < 3; i++) begin
      wr_op(2'b01, 5'd0, 0); #1;
      chk("t2_ready", issue_ready, 1);
      cyc();
    end
    wr_op(2'b01, 5'd0, 0); #1;
    chk("t2_struct_stall", stall, 1);
    chk("t2_struct_ready", issue_ready, 0);
    chk("t2_busy31", busy_vec, 32'h8000_0000);
    chk("t2_err", err, 0);
    for (int i = 0; i < 3; i++) begin
      idle(); wb_valid = 1; wb_reg = 5'd31;
      cyc();
    end
    idle(); #1;
    chk("t2_drained", busy_vec, 0);
    chk("t2_err_after", err, 0);

    // writes to r0 are not tracked
    wr_op(2'b00, 5'd0, 0); #1;
    chk("t3_r0_ready", issue_ready, 1);
    cyc();
    rd_rs(5'd0); #1;
    chk("t3_r0_busy", busy_vec, 0);
    chk("t3_r0_stall", stall, 0);
    cyc();

    // rt operand: hazard only when use_rt
    wr_op(2'b10, 5'd9, 0); cyc();
    idle(); issue_valid = 1; issue_rt = 5'd9; #1;
    chk("t3_rt_unused", stall, 0);
    issue_use_rt = 1; #1;
    chk("t3_rt_used", stall, 1);
    idle(); wb_valid = 1; wb_reg = 5'd9; cyc();
    idle();

    // ALU writer then reader
    wr_op(2'b10, 5'd5, 0); cyc();
    rd_rs(5'd5); #1;
`ifdef SCOREBOARD_FWD_EN
    chk("t4_alu_use", stall, 0);
`else
    chk("t4_alu_use", stall, 1);
`endif
    idle(); wb_valid = 1; wb_reg = 5'd5; cyc();
    // load writer then reader
    wr_op(2'b10, 5'd5, 1); cyc();
    rd_rs(5'd5); #1;
    chk("t4_load_use", stall, 1);
    cyc(); #1;
    chk("t4_load_use_b", stall, 1);
    wb_valid = 1; wb_reg = 5'd5; #1;
    chk("t4_load_ret", stall, 0);
    cyc(); idle(); #1;
    chk("t4_busy", busy_vec, 0);

    // flush with pend[3]=2 and a same-cycle issue
    wr_op(2'b10, 5'd3, 0); cyc();
    wr_op(2'b10, 5'd3, 0); cyc();
    idle(); #1;
    chk("t5_busy3", busy_vec, 32'h0000_0008);
    wr_op(2'b10, 5'd4, 0); flush = 1; #1;
    chk("t5_flush_ready", issue_ready, 0);
    chk("t5_flush_stall", stall, 0);
    cyc(); idle(); #1;
    chk("t5_flush_busy", busy_vec, 0);
    chk("t5_err_pre", err, 0);
    wb_valid = 1; wb_reg = 5'd3; cyc(); idle(); #1;
    chk("t5_err_set", err, 1);
    cyc();
    chk("t5_err_sticky", err, 1);

    // reset mid-operation with pend[7]=1
    wr_op(2'b10, 5'd7, 0); cyc();
    rd_rs(5'd7); #1;
    chk("t6_pre_stall", stall, 1);
    chk("t6_pre_busy", busy_vec, 32'h0000_0080);
    rst_n = 0; #1;
    chk("t6_rst_stall", stall, 0);
    chk("t6_rst_ready", issue_ready, 0);
    chk("t6_rst_busy", busy_vec, 0);
    chk("t6_rst_err", err, 0);
    cyc(); cyc(); cyc();
    rst_n = 1; #1;
    chk("t6_post_stall", stall, 0);
    chk("t6_post_ready", issue_ready, 1);
    cyc();

    // retire to r0 is ignored without error
    idle(); wb_valid = 1; wb_reg = 5'd0; cyc(); idle(); #1;
    chk("t7_r0_wb_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dst_reg_scoreboard.md
# dst_reg_scoreboard

- Decode-stage hazard controller for the destination-register path of the MIPS pipeline.
- Resolves each issuing instruction's write target with the same select encoding as the destination mux: rt, r31 or rd.
- Tracks in-flight writes per architectural register and stalls issue while a source operand has a pending writer.
- Sits between decode and the pipeline issue point; takes retire notifications from write-back.

## Interface
- NBITS, 5, register address width
- NREGS, 32, number of architectural registers (2**NBITS)
- CNTBITS, 2, width of the per-register in-flight counter (max 3 outstanding writes)
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- issue_valid  in  1  decode presents an instruction
- issue_rs, issue_rt, issue_rd  in  NBITS  instruction register fields
- issue_use_rs, issue_use_rt  in  1  operand actually read
- issue_wr  in  1  instruction writes a register
- issue_sel_reg  in  2  destination select: 00 rt, 01 r31, 10 rd, 11 no write
- issue_is_load  in  1  instruction is a load
- wb_valid  in  1  write-back retires a write this cycle
- wb_reg  in  NBITS  retired destination register
- flush  in  1  discard all in-flight tracking
- stall  out  1  hold decode this cycle
- issue_ready  out  1  instruction accepted this cycle
- busy_vec  out  NREGS  bit i = register i has nonzero pending count (registered)
- err  out  1  sticky counter overflow/underflow flag

## Operation
- Destination: sel 00 -> issue_rt; 01 -> 5'd31; 10 -> issue_rd; 11 or issue_wr=0 -> no write. Register 0 is never tracked.
- Each register r has:
  - pend[r], CNTBITS wide;
  - ld[r], set when the newest pending writer of r is a load.
- Effective count: eff[r] = pend[r] - 1 if wb_valid && wb_reg==r && pend[r]!=0, otherwise pend[r]. The write-through register file makes a same-cycle retire visible to decode.
- Hazard on source s exists when use_s, s!=0 and eff[s]!=0.
- Structural stall when the destination d has pend[d] at its maximum value.
- stall = issue_valid && !flush && (any hazard || structural). issue_ready = issue_valid && !stall && !flush.
- On issue_ready with destination d != 0:
  - pend[d] increments;
  - ld[d] takes issue_is_load.
- On wb_valid with wb_reg != 0:
  - pend[wb_reg] decrements when nonzero;
  - a retire to a register with pend=0 is ignored and sets err.
- Issue and retire to the same register in the same cycle: net count unchanged; ld[d] still updated from the issue.
- ld[r] clears whenever pend[r] reaches 0.
- flush has priority over issue and retire: all pend and ld clear at the next edge. err is not cleared by flush.
- err is cleared only by reset.

## Timing
- stall and issue_ready are combinational from inputs and registered state; zero latency.
- pend, ld, busy_vec and err update at the rising edge after the event; busy_vec lags a retire by one cycle.
- Reset (async assert, sync release):
  - all pend, ld, busy_vec and err are 0;
  - stall and issue_ready are forced to 0 while rst_n=0.
- Reset mid-operation discards every in-flight entry; no retire is expected afterwards.
- Throughput: one issue and one retire per cycle.

## Configuration
- Macro SCOREBOARD_FWD_EN.
  - Defined: the pipeline forwards ALU results, so a source hazard stalls only when eff[s]!=0 and ld[s]=1 (load-use). The structural stall is unchanged.
  - Undefined: ld is still maintained but ignored; any pending writer stalls.

## Test plan
- Issue an instruction with sel=10 and rd=8, then a reader with use_rs=1, rs=8 on the next cycle; retire r8 two cycles later. Required: stall=1 until the retire cycle, stall=0 in the retire cycle, busy_vec[8] drops at the following edge.
- Issue sel=01 (writes r31) three times with no retires. Required: pend[31]=3; a fourth writer to r31 gets stall=1; err stays 0.
- Issue with sel=00 and rt=0, then read r0. Required: no tracking (busy_vec=0) and no stall.
- With SCOREBOARD_FWD_EN defined:
  - add to r5, then read r5. Required: stall=0.
  - load to r5, then read r5. Required: stall=1 until the retire.
- Assert flush with pend[3]=2 plus a same-cycle issue. Required: issue_ready=0, busy_vec=0 next cycle; a later wb_reg=3 sets err=1.
- Assert rst_n low for 3 cycles with pend[7]=1. Required: all outputs 0 immediately; after release, a read of r7 gets stall=0.
